// File: rtl/alu_arbiter.sv
// Two-port valid/ready arbiter in front of a shared combinational ALU.
// Define ALU_ARB_RR_EN for round-robin arbitration; fixed priority (port 0) otherwise.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic [WIDTH-1:0] alu_src_a,
  output logic [WIDTH-1:0] alu_src_b,
  output logic [OPW-1:0]   alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic             owner_r;
  logic             grant_s;
  logic             grant_valid_s;
  logic [WIDTH-1:0] src_a_r, src_b_r, result_r;
  logic [OPW-1:0]   control_r;
  logic             zero_r;
`ifdef ALU_ARB_RR_EN
  logic             last_grant_r;
`endif

  // Winner selection; grant_s is the index of the winning port
  always_comb begin
    grant_valid_s = req0_valid | req1_valid;
`ifdef ALU_ARB_RR_EN
    if (req0_valid && req1_valid) begin
      grant_s = ~last_grant_r;
    end else begin
      grant_s = ~req0_valid;
    end
`else
    grant_s = ~req0_valid;
`endif
  end

  // Next-state and handshake decode; ready is gated by rst_n so it drops with reset
  always_comb begin
    state_s    = state_r;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_valid_s && rst_n) begin
          state_s    = EXEC;
          req0_ready = ~grant_s;
          req1_ready = grant_s;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: begin
        state_s = RESP;
      end
      RESP: begin
        if ((!owner_r && rsp0_ready) || (owner_r && rsp1_ready)) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, request capture and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      owner_r   <= 1'b0;
      src_a_r   <= {WIDTH{1'b0}};
      src_b_r   <= {WIDTH{1'b0}};
      control_r <= {OPW{1'b0}};
      result_r  <= {WIDTH{1'b0}};
      zero_r    <= 1'b0;
`ifdef ALU_ARB_RR_EN
      last_grant_r <= 1'b1;
`endif
    end else begin
      state_r <= state_s;
      if (state_r == IDLE && grant_valid_s) begin
        owner_r   <= grant_s;
        src_a_r   <= grant_s ? req1_a : req0_a;
        src_b_r   <= grant_s ? req1_b : req0_b;
        control_r <= grant_s ? req1_op : req0_op;
`ifdef ALU_ARB_RR_EN
        last_grant_r <= grant_s;
`endif
      end
      if (state_r == EXEC) begin
        result_r <= alu_result;
        zero_r   <= alu_zero;
      end
    end
  end

  assign alu_src_a   = src_a_r;
  assign alu_src_b   = src_b_r;
  assign alu_control = control_r;
  assign rsp_result  = result_r;
  assign rsp_zero    = zero_r;
  assign rsp0_valid  = (state_r == RESP) && !owner_r;
  assign rsp1_valid  = (state_r == RESP) && owner_r;
  assign busy        = (state_r != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural ALU and an expected-response queue.
module tb_alu_arbiter;
  localparam int W = 32;
  localparam int O = 4;

  logic         clk, rst_n;
  logic         req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic         req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [O-1:0] req0_op, req1_op;
  logic [W-1:0] rsp_result, alu_src_a, alu_src_b, alu_result;
  logic         rsp_zero, alu_zero, busy;
  logic [O-1:0] alu_control;

  typedef struct packed {
    logic         port;
    logic [W-1:0] result;
    logic         zero;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.WIDTH(W), .OPW(O)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
  );

  // Reference ALU: AND, OR, ADD, SUB, signed SLT; undefined codes give 0
  function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [O-1:0] op);
    case (op)
      4'b0000: alu_f = a & b;
      4'b0001: alu_f = a | b;
      4'b0010: alu_f = a + b;
      4'b0110: alu_f = a - b;
      4'b0111: alu_f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: alu_f = 32'd0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_src_a, alu_src_b, alu_control);
  assign alu_zero   = (alu_result == 32'd0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request, wait for acceptance, record the expected response, then withdraw
  task automatic issue(input int port, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [O-1:0] op, output bit ok);
    exp_t e;
    ok = 1'b0;
    @(negedge clk);
    if (port == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end
    for (int i = 0; i < 20; i++) begin
      #1;
      if ((port == 0) ? req0_ready : req1_ready) begin
        e.port = (port != 0); e.result = alu_f(a, b, op); e.zero = (e.result == 32'd0);
        q.push_back(e);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    #1;
  endtask

  task automatic wait_rsp(output bit ok, output logic port);
    ok = 1'b0; port = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp0_valid || rsp1_valid) begin
        ok = 1'b1; port = rsp1_valid;
        return;
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic consume(input logic port);
    if (port) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b00000) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=00000",
                         {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy});
    end
    checks++;
    if ({rsp_result, rsp_zero, alu_src_a, alu_src_b, alu_control} !== {(3*W+O+1){1'b0}}) begin
      errors++; $display("FAIL reset_data got=%h/%b/%h/%h/%h exp=0", rsp_result, rsp_zero,
                         alu_src_a, alu_src_b, alu_control);
    end
  endtask

  task automatic test_single_op;
    bit ok; logic port; exp_t e;
    issue(0, 32'd5, 32'd7, 4'b0010, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_accept got=timeout exp=ready"); end
    checks++;
    if ({rsp0_valid, busy, alu_src_a, alu_src_b, alu_control} !== {1'b0, 1'b1, 32'd5, 32'd7, 4'b0010}) begin
      errors++; $display("FAIL single_exec got=%b%b %0d %0d %h exp=01 5 7 2", rsp0_valid, busy,
                         alu_src_a, alu_src_b, alu_control);
    end
    @(negedge clk); #1;
    checks++;
    if ({rsp0_valid, rsp1_valid} !== 2'b10) begin
      errors++; $display("FAIL single_latency got=%b exp=10", {rsp0_valid, rsp1_valid});
    end
    wait_rsp(ok, port);
    e = q.pop_front();
    checks++;
    if (!ok || port !== e.port || rsp_result !== e.result || rsp_zero !== e.zero) begin
      errors++; $display("FAIL single_rsp got=%b/%0d/%b exp=%b/%0d/%b", port, rsp_result,
                         rsp_zero, e.port, e.result, e.zero);
    end
    consume(port);
  endtask

  task automatic test_zero_flag;
    bit ok; logic port; exp_t e;
    issue(1, 32'd9, 32'd9, 4'b0110, ok);
    wait_rsp(ok, port);
    e = q.pop_front();
    checks++;
    if (!ok || port !== e.port || rsp_result !== e.result || rsp_zero !== e.zero ||
        rsp0_valid !== 1'b0) begin
      errors++; $display("FAIL zero_rsp got=%b/%0d/%b exp=%b/%0d/%b", port, rsp_result,
                         rsp_zero, e.port, e.result, e.zero);
    end
    consume(port);
  endtask

  task automatic test_backpressure;
    bit ok; logic port; exp_t e;
    issue(0, 32'hFFFF_FFFF, 32'd1, 4'b0111, ok);
    wait_rsp(ok, port);
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_op = 4'b0001;
    e = q.pop_front();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++;
      if (!ok || rsp0_valid !== 1'b1 || rsp_result !== e.result || busy !== 1'b1 ||
          req1_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold cyc=%0d got=%b/%0d/%b/%b exp=1/%0d/1/0", i, rsp0_valid,
                           rsp_result, busy, req1_ready, e.result);
      end
    end
    rsp0_ready = 1'b1; #1;
    checks++;
    if (req1_ready !== 1'b0) begin
      errors++; $display("FAIL bp_no_same_cycle_grant got=%b exp=0", req1_ready);
    end
    @(negedge clk); rsp0_ready = 1'b0; #1;
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      errors++; $display("FAIL bp_next_grant got=%b%b exp=01", req0_ready, req1_ready);
    end else begin
      e.port = 1'b1; e.result = alu_f(req1_a, req1_b, req1_op); e.zero = (e.result == 32'd0);
      q.push_back(e);
    end
    @(negedge clk); req1_valid = 1'b0; #1;
    wait_rsp(ok, port);
    e = q.pop_front();
    checks++;
    if (!ok || port !== e.port || rsp_result !== e.result || rsp_zero !== e.zero) begin
      errors++; $display("FAIL bp_followup got=%b/%0d exp=%b/%0d", port, rsp_result, e.port, e.result);
    end
    consume(port);
  endtask

  task automatic test_contention;
    bit ok; logic port, got; exp_t e;
    int exp_order[4];
`ifdef ALU_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd1; req0_op = 4'b0010;
    req1_valid = 1'b1; req1_a = 32'd50;  req1_b = 32'd8; req1_op = 4'b0110;
    for (int k = 0; k < 4; k++) begin
      ok = 1'b0; got = 1'b0;
      for (int i = 0; i < 20; i++) begin
        #1;
        if (req0_ready || req1_ready) begin
          ok = !(req0_ready && req1_ready);
          got = req1_ready;
          e.port = got;
          e.result = got ? alu_f(req1_a, req1_b, req1_op) : alu_f(req0_a, req0_b, req0_op);
          e.zero = (e.result == 32'd0);
          q.push_back(e);
          break;
        end
        @(negedge clk);
      end
      checks++;
      if (!ok || int'(got) != exp_order[k]) begin
        errors++; $display("FAIL contention_grant op=%0d got=%0d exp=%0d", k, got, exp_order[k]);
      end
      @(negedge clk); #1;
      wait_rsp(ok, port);
      e = q.pop_front();
      checks++;
      if (!ok || port !== e.port || rsp_result !== e.result) begin
        errors++; $display("FAIL contention_rsp op=%0d got=%b/%0d exp=%b/%0d", k, port,
                           rsp_result, e.port, e.result);
      end
      consume(port);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_reset_exec;
    bit ok; logic port; exp_t e;
    issue(0, 32'd11, 32'd22, 4'b0010, ok);
    rst_n = 1'b0; req1_valid = 1'b1; #1;
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b00000 ||
        rsp_result !== 32'd0) begin
      errors++; $display("FAIL rst_exec_outputs got=%b/%0d exp=00000/0",
                         {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy}, rsp_result);
    end
    q.delete();
    @(negedge clk); req1_valid = 1'b0; rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL rst_exec_no_rsp cyc=%0d got=%b%b%b exp=000", i, rsp0_valid,
                           rsp1_valid, busy);
      end
      @(negedge clk);
    end
    issue(1, 32'd2, 32'd3, 4'b0010, ok);
    wait_rsp(ok, port);
    e = q.pop_front();
    checks++;
    if (!ok || port !== 1'b1 || rsp_result !== 32'd5 || e.result !== 32'd5) begin
      errors++; $display("FAIL rst_exec_followup got=%b/%0d exp=1/5", port, rsp_result);
    end
    consume(port);
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = 32'd0; req0_b = 32'd0; req0_op = 4'b0000; rsp0_ready = 1'b0;
    req1_valid = 1'b0; req1_a = 32'd0; req1_b = 32'd0; req1_op = 4'b0000; rsp1_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_single_op();
    test_zero_flag();
    test_backpressure();
    test_contention();
    test_reset_exec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
